lv8_mc_sequencer: RTL and testbench

Multicycle control sequencer for the LEGv8 datapath. It steps each instruction through fetch, instruction-register load, decode, optional memory access and commit. It gates the register-file write and status-flag load that the combinational decoder requests, and it drives all RAM, bus-enable and PC-select strobes. It sits between the instruction decoder, the program counter, the shared RAM port and the register file.

---
 rtl/lv8_pkg.sv | 40 ++++
 rtl/lv8_wait_timer.sv | 30 +++
 rtl/lv8_mc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_lv8_mc_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lv8_pkg.sv
// Shared LEGv8 control definitions: sequencer states, decoder op classes and PC-select codes.
// Imported by the sequencer and by the instruction decoder.
package lv8_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_IR_LOAD = 3'd2,
    S_DECODE  = 3'd3,
    S_MEM     = 3'd4,
    S_COMMIT  = 3'd5,
    S_HALT    = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU    = 3'b000,
    OP_LOAD   = 3'b001,
    OP_STORE  = 3'b010,
    OP_BRANCH = 3'b011,
    OP_BR     = 3'b100,
    OP_NOP    = 3'b101,
    OP_ILL    = 3'b110,
    OP_HALT   = 3'b111
  } op_class_t;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_BR   = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  function automatic logic [1:0] pc_sel_for(op_class_t c);
    case (c)
      OP_BRANCH: return PC_BR;
      OP_BR:     return PC_REG;
      default:   return PC_INC;
    endcase
  endfunction

endpackage

// File: rtl/lv8_wait_timer.sv
// RAM wait watchdog: counts stalled cycles, expired flags the WAIT_MAX-th stalled cycle.
// Combinational expired (same cycle as the last tick); clear dominates tick.
module lv8_wait_timer #(
  parameter int WAIT_MAX = 8,
  parameter int W        = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(WAIT_MAX - 1);

  logic [W-1:0] cnt;

  assign expired = tick && (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lv8_mc_sequencer.sv
// Multicycle LEGv8 sequencer: 4 cycles per ALU/branch instruction, 5 for LOAD/STORE, all outputs registered.
// Stalls in FETCH/MEM until ram_ready; WAIT_MAX stalled cycles in a row ends in FAULT.
module lv8_mc_sequencer
  import lv8_pkg::*;
#(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op_class,
  input  logic             dec_wr,
  input  logic             dec_sfl,
  input  logic             ram_ready,
  output logic             RCS,
  output logic             RR,
  output logic             WRR,
  output logic             EN_ADDR_PC,
  output logic             EN_ADDR_ALU,
  output logic             IL,
  output logic [1:0]       PC_SEL,
  output logic             WR,
  output logic             SFL,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retire_count
);

  state_t    state;
  op_class_t cls;
  op_class_t op_cls;
  logic      lat_wr;
  logic      lat_sfl;
  logic      in_wait;
  logic      expired;

  assign op_cls  = op_class_t'(op_class);
  assign in_wait = (state == S_FETCH) || (state == S_MEM);

  lv8_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .W        (8)
  ) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!in_wait),
    .tick    (in_wait && !ram_ready),
    .expired (expired)
  );

  // Outputs are computed for the state being entered, so every strobe is a flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cls          <= OP_ALU;
      lat_wr       <= 1'b0;
      lat_sfl      <= 1'b0;
      RCS          <= 1'b0;
      RR           <= 1'b0;
      WRR          <= 1'b0;
      EN_ADDR_PC   <= 1'b0;
      EN_ADDR_ALU  <= 1'b0;
      IL           <= 1'b0;
      PC_SEL       <= PC_HOLD;
      WR           <= 1'b0;
      SFL          <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      retire_count <= '0;
    end else begin
      RCS         <= 1'b0;
      RR          <= 1'b0;
      WRR         <= 1'b0;
      EN_ADDR_PC  <= 1'b0;
      EN_ADDR_ALU <= 1'b0;
      IL          <= 1'b0;
      PC_SEL      <= PC_HOLD;
      WR          <= 1'b0;
      SFL         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_FETCH;
            busy       <= 1'b1;
            RCS        <= 1'b1;
            RR         <= 1'b1;
            EN_ADDR_PC <= 1'b1;
          end
        end
        S_FETCH: begin
          if (ram_ready) begin
            state <= S_IR_LOAD;
            IL    <= 1'b1;
          end else if (expired) begin
            state <= S_FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else begin
            RCS        <= 1'b1;
            RR         <= 1'b1;
            EN_ADDR_PC <= 1'b1;
          end
        end
        S_IR_LOAD: state <= S_DECODE;
        S_DECODE: begin
          cls     <= op_cls;
          lat_wr  <= dec_wr;
          lat_sfl <= dec_sfl;
          case (op_cls)
            OP_LOAD, OP_STORE: begin
              state       <= S_MEM;
              RCS         <= 1'b1;
              EN_ADDR_ALU <= 1'b1;
              RR          <= (op_cls == OP_LOAD);
              WRR         <= (op_cls == OP_STORE);
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end
            OP_ILL: begin
              state <= S_FAULT;
              fault <= 1'b1;
              busy  <= 1'b0;
            end
            default: begin
              state  <= S_COMMIT;
              PC_SEL <= pc_sel_for(op_cls);
              WR     <= dec_wr && (op_cls == OP_ALU);
              SFL    <= dec_sfl && (op_cls == OP_ALU);
            end
          endcase
        end
        S_MEM: begin
          if (ram_ready) begin
            state  <= S_COMMIT;
            PC_SEL <= pc_sel_for(cls);
            WR     <= lat_wr && (cls == OP_LOAD);
            SFL    <= lat_sfl && (cls == OP_ALU);
          end else if (expired) begin
            state <= S_FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else begin
            RCS         <= 1'b1;
            EN_ADDR_ALU <= 1'b1;
            RR          <= (cls == OP_LOAD);
            WRR         <= (cls == OP_STORE);
          end
        end
        S_COMMIT: begin
          state        <= S_FETCH;
          retire_count <= retire_count + CNT_W'(1);
          RCS          <= 1'b1;
          RR           <= 1'b1;
          EN_ADDR_PC   <= 1'b1;
        end
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_lv8_mc_sequencer.sv
// Self-checking bench for lv8_mc_sequencer: per-cycle traces plus a commit scoreboard.
`timescale 1ns/1ps
module tb_lv8_mc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_class = 3'b110;
  logic        dec_wr = 1'b0;
  logic        dec_sfl = 1'b0;
  logic        ram_ready = 1'b1;
  logic        RCS, RR, WRR, EN_ADDR_PC, EN_ADDR_ALU, IL, WR, SFL;
  logic [1:0]  PC_SEL;
  logic        busy, halted, fault;
  logic [15:0] retire_count;

  lv8_mc_sequencer #(.WAIT_MAX(8), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op_class(op_class),
    .dec_wr(dec_wr), .dec_sfl(dec_sfl), .ram_ready(ram_ready),
    .RCS(RCS), .RR(RR), .WRR(WRR), .EN_ADDR_PC(EN_ADDR_PC), .EN_ADDR_ALU(EN_ADDR_ALU),
    .IL(IL), .PC_SEL(PC_SEL), .WR(WR), .SFL(SFL), .busy(busy), .halted(halted),
    .fault(fault), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic rcs, rr, wrr, en_pc, en_alu, il;
    logic [1:0] pc_sel;
    logic wr, sfl, busy, halted, fault;
  } snap_t;

  int          checks = 0;
  int          errors = 0;
  snap_t       tr[$];
  logic [3:0]  exp_q[$];
  logic [3:0]  obs_q[$];
  logic [15:0] exp_retire = '0;

  always @(negedge clock) if (reset_n && PC_SEL != 2'b00) obs_q.push_back({PC_SEL, WR, SFL});

  task automatic tick;
    @(posedge clock); #1;
  endtask

  function automatic snap_t take();
    return {RCS, RR, WRR, EN_ADDR_PC, EN_ADDR_ALU, IL, PC_SEL, WR, SFL, busy, halted, fault};
  endfunction

  task automatic do_reset;
    reset_n = 1'b0; start = 1'b0; ram_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    exp_q.delete(); obs_q.delete(); exp_retire = '0;
  endtask

  // Steps one instruction from FETCH to its terminal state, recording each cycle in tr.
  task automatic run_instr(input logic [2:0] cls, input logic w, input logic s,
                           input int fw, input int mw, input bit start_it);
    int fcnt = 0, mcnt = 0, il_idx = -100;
    bit done = 0;
    snap_t sn;
    tr.delete();
    if (cls != 3'b111 && cls != 3'b110 && fw < 8 && mw < 8) begin
      exp_q.push_back({(cls == 3'b011) ? 2'b10 : (cls == 3'b100) ? 2'b11 : 2'b01,
                       w && (cls == 3'b000 || cls == 3'b001), s && (cls == 3'b000)});
      exp_retire = exp_retire + 16'd1;
    end
    op_class = 3'b110; dec_wr = ~w; dec_sfl = ~s;
    if (start_it) begin start = 1'b1; tick(); start = 1'b0; end
    for (int i = 0; i < 60 && !done; i++) begin
      sn = take();
      if (sn.il) begin il_idx = i; op_class = cls; dec_wr = w; dec_sfl = s; end
      if (i == il_idx + 2) begin op_class = 3'b110; dec_wr = ~w; dec_sfl = ~s; end
      if (sn.en_pc) begin ram_ready = (fcnt >= fw); fcnt++; end
      else if (sn.en_alu) begin ram_ready = (mcnt >= mw); mcnt++; end
      else ram_ready = 1'b1;
      tr.push_back(sn);
      done = (sn.pc_sel != 2'b00) || sn.halted || sn.fault;
      tick();
    end
    if (!done) begin checks++; errors++; $display("FAIL run_timeout cls=%b no terminal state in 60 cycles", cls); end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({RCS, RR, WRR, EN_ADDR_PC, EN_ADDR_ALU, IL, WR, SFL} !== 8'h00) begin errors++; $display("FAIL reset_strobes got %b want 0", {RCS, RR, WRR, EN_ADDR_PC, EN_ADDR_ALU, IL, WR, SFL}); end
    checks++; if (PC_SEL !== 2'b00) begin errors++; $display("FAIL reset_pc_sel got %b want 00", PC_SEL); end
    checks++; if ({busy, halted, fault} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {busy, halted, fault}); end
    checks++; if (retire_count !== 16'd0) begin errors++; $display("FAIL reset_retire got %0d want 0", retire_count); end
    do_reset();
  endtask

  task automatic test_alu;
    logic [3:0] e, o;
    do_reset();
    run_instr(3'b000, 1'b1, 1'b1, 0, 0, 1'b1);
    checks++; if (tr.size() !== 4) begin errors++; $display("FAIL alu_latency got %0d want 4", tr.size()); end
    checks++; if ({tr[0].rcs, tr[0].rr, tr[0].en_pc, tr[0].il} !== 4'b1110) begin errors++; $display("FAIL alu_fetch got %b want 1110", {tr[0].rcs, tr[0].rr, tr[0].en_pc, tr[0].il}); end
    checks++; if ({tr[1].il, tr[1].rcs, tr[2].il, tr[2].rcs} !== 4'b1000) begin errors++; $display("FAIL alu_il got %b want 1000", {tr[1].il, tr[1].rcs, tr[2].il, tr[2].rcs}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL alu_commit missing, want %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL alu_commit got %b want %b", o, e); end end
    end
    checks++; if (retire_count !== exp_retire) begin errors++; $display("FAIL alu_retire got %0d want %0d", retire_count, exp_retire); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL alu_opclass_outside_decode got fault=%b want 0", fault); end
  endtask

  task automatic test_load_wait;
    int mem_rd = 0, bad = 0;
    logic [3:0] e, o;
    run_instr(3'b001, 1'b1, 1'b1, 0, 3, 1'b0);
    foreach (tr[i]) begin
      if (tr[i].rr && tr[i].en_alu && tr[i].rcs) mem_rd++;
      if (tr[i].il && (tr[i].rcs || tr[i].rr || tr[i].wrr)) bad++;
    end
    checks++; if (tr.size() !== 8) begin errors++; $display("FAIL load_latency got %0d want 8", tr.size()); end
    checks++; if (mem_rd !== 4) begin errors++; $display("FAIL load_mem_cycles got %0d want 4", mem_rd); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL load_il_overlap got %0d want 0", bad); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL load_commit missing, want %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL load_commit got %b want %b", o, e); end end
    end
    checks++; if (retire_count !== exp_retire) begin errors++; $display("FAIL load_retire got %0d want %0d", retire_count, exp_retire); end
  endtask

  task automatic test_store;
    int wr_cyc = 0, rd_mem = 0, both = 0;
    logic [3:0] e, o;
    run_instr(3'b010, 1'b1, 1'b1, 0, 0, 1'b0);
    foreach (tr[i]) begin
      if (tr[i].wrr && tr[i].en_alu && tr[i].rcs) wr_cyc++;
      if (tr[i].rr && tr[i].en_alu) rd_mem++;
      if (tr[i].rr && tr[i].wrr) both++;
    end
    checks++; if (tr.size() !== 5) begin errors++; $display("FAIL store_latency got %0d want 5", tr.size()); end
    checks++; if ({wr_cyc, rd_mem, both} !== {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL store_strobes got wrr=%0d rr=%0d both=%0d want 1 0 0", wr_cyc, rd_mem, both); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL store_commit missing, want %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL store_commit got %b want %b", o, e); end end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e, o;
    do_reset();
    run_instr(3'b011, 1'b1, 1'b1, 0, 0, 1'b1);
    checks++; if (tr.size() !== 4) begin errors++; $display("FAIL b2b_branch_latency got %0d want 4", tr.size()); end
    run_instr(3'b100, 1'b1, 1'b1, 0, 0, 1'b0);
    checks++; if (tr.size() !== 4) begin errors++; $display("FAIL b2b_br_latency got %0d want 4", tr.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_commit missing, want %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL b2b_commit got %b want %b", o, e); end end
    end
    checks++; if (retire_count !== 16'd2) begin errors++; $display("FAIL b2b_retire got %0d want 2", retire_count); end
  endtask

  task automatic test_ready_boundary;
    logic [3:0] e, o;
    do_reset();
    run_instr(3'b101, 1'b0, 1'b0, 7, 0, 1'b1);
    checks++; if (tr.size() !== 11 || fault !== 1'b0) begin errors++; $display("FAIL fetch_boundary got len=%0d fault=%b want 11 0", tr.size(), fault); end
    run_instr(3'b001, 1'b1, 1'b0, 0, 7, 1'b0);
    checks++; if (tr.size() !== 12 || fault !== 1'b0) begin errors++; $display("FAIL mem_boundary got len=%0d fault=%b want 12 0", tr.size(), fault); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL boundary_commit missing, want %b", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL boundary_commit got %b want %b", o, e); end end
    end
  endtask

  task automatic test_timeout;
    int fetches = 0;
    snap_t last;
    do_reset();
    run_instr(3'b000, 1'b0, 1'b0, 100, 0, 1'b1);
    foreach (tr[i]) if (tr[i].en_pc) fetches++;
    last = tr[tr.size()-1];
    checks++; if (tr.size() !== 9 || fetches !== 8) begin errors++; $display("FAIL fetch_timeout got len=%0d fetches=%0d want 9 8", tr.size(), fetches); end
    checks++; if ({last.fault, last.rcs, last.en_pc, last.busy} !== 4'b1000) begin errors++; $display("FAIL fault_outputs got %b want 1000", {last.fault, last.rcs, last.en_pc, last.busy}); end
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    checks++; if ({fault, RCS, busy} !== 3'b100) begin errors++; $display("FAIL fault_sticky got %b want 100", {fault, RCS, busy}); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL fault_no_commit got %0d want 0", obs_q.size()); end
    reset_n = 1'b0; #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_reset got %b want 0", fault); end
    do_reset();
    run_instr(3'b010, 1'b0, 1'b0, 0, 100, 1'b1);
    checks++; if (tr.size() !== 12 || fault !== 1'b1 || WRR !== 1'b0) begin errors++; $display("FAIL mem_timeout got len=%0d fault=%b wrr=%b want 12 1 0", tr.size(), fault, WRR); end
  endtask

  task automatic test_halt;
    int fetched = 0;
    do_reset();
    run_instr(3'b111, 1'b1, 1'b1, 0, 0, 1'b1);
    checks++; if (tr.size() !== 4 || halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL halt_state got len=%0d halted=%b busy=%b want 4 1 0", tr.size(), halted, busy); end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin if (RCS || RR || IL) fetched++; tick(); end
    checks++; if (fetched !== 0 || halted !== 1'b1 || obs_q.size() !== 0) begin errors++; $display("FAIL halt_no_fetch got fetched=%0d halted=%b commits=%0d want 0 1 0", fetched, halted, obs_q.size()); end
  endtask

  task automatic test_reset_mid_mem;
    bit seen = 0;
    do_reset();
    op_class = 3'b010; dec_wr = 1'b1; dec_sfl = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (WRR) begin seen = 1; ram_ready = 1'b0; end
      else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_mem_reach got wrr_seen=0 want 1"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({WRR, RCS, EN_ADDR_ALU, busy} !== 4'b0000) begin errors++; $display("FAIL mid_mem_async got %b want 0000", {WRR, RCS, EN_ADDR_ALU, busy}); end
    tick(); reset_n = 1'b1; ram_ready = 1'b1; tick();
    checks++; if ({RCS, busy} !== 2'b00) begin errors++; $display("FAIL mid_mem_idle got %b want 00", {RCS, busy}); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if ({RCS, RR, EN_ADDR_PC, busy} !== 4'b1111) begin errors++; $display("FAIL mid_mem_restart got %b want 1111", {RCS, RR, EN_ADDR_PC, busy}); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_ready_boundary();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
